// File: rtl/ram_w_pkg.sv
// rtl/ram_w_pkg.sv - shared constants and types for the ping-pong weight RAM
package ram_w_pkg;

    localparam int LP_DATA_WIDTH    = 8;
    localparam int LP_DEPTH         = 1024;
    localparam int LP_RD_LAT_BASE   = 1;
    localparam int LP_RD_LAT_OUTREG = 2;

    typedef logic bank_idx_t;

endpackage

// File: rtl/ram_w_bank.sv
// rtl/ram_w_bank.sv - one simple-dual-port weight bank with a registered read port
module ram_w_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Callers only assert i_we / i_re with in-range addresses.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_w_pingpong.sv
// rtl/ram_w_pingpong.sv - double-buffered weight RAM; RAM_W_OUTREG_EN adds a read output register
module ram_w_pingpong
    import ram_w_pkg::*;
#(
    parameter int DATA_WIDTH = LP_DATA_WIDTH,
    parameter int DEPTH      = LP_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_release,
    output logic                  rd_ready,
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic                  err
);

    localparam logic [ADDR_W:0] LP_DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [1:0]            r_full;
    bank_idx_t             r_wr_bank;
    bank_idx_t             r_rd_bank;
    bank_idx_t             r_rd_sel;
    logic                  r_rd_zero;
    logic                  r_rd_valid;
    logic                  r_err;

    logic                  w_wr_ready;
    logic                  w_rd_ready;
    logic                  w_wr_in_rng;
    logic                  w_rd_in_rng;
    logic                  w_wr_fire;
    logic                  w_rd_acc;
    logic                  w_rd_fire;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_bank_rdata [2];
    logic [DATA_WIDTH-1:0] w_rd_data_s1;

    assign w_wr_ready  = !r_full[r_wr_bank];
    assign w_rd_ready  = r_full[r_rd_bank];
    assign w_wr_in_rng = ({1'b0, wr_addr} < LP_DEPTH_W);
    assign w_rd_in_rng = ({1'b0, rd_addr} < LP_DEPTH_W);
    assign w_wr_fire   = wr_en && w_wr_ready && w_wr_in_rng;
    assign w_rd_acc    = rd_en && w_rd_ready;
    assign w_rd_fire   = w_rd_acc && w_rd_in_rng;

    assign w_err = ((wr_en || wr_done) && !w_wr_ready)
                || ((rd_en || rd_release) && !w_rd_ready)
                || (wr_en && w_wr_ready && !w_wr_in_rng)
                || (w_rd_acc && !w_rd_in_rng);

    for (genvar g = 0; g < 2; g++) begin : g_bank
        ram_w_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_W     (ADDR_W)
        ) u_bank (
            .i_clk   (clka),
            .i_we    (w_wr_fire && (r_wr_bank == bank_idx_t'(g))),
            .i_waddr (wr_addr),
            .i_wdata (wr_data),
            .i_re    (w_rd_fire && (r_rd_bank == bank_idx_t'(g))),
            .i_raddr (rd_addr),
            .o_rdata (w_bank_rdata[g])
        );
    end

    // Only one of the two ready flags is high when the pointers coincide,
    // so the set and clear below never touch the same flag bit.
    always_ff @(posedge clka) begin
        if (rsta) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_rd_zero  <= 1'b1;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err      <= w_err;
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_zero <= !w_rd_in_rng;
                r_rd_sel  <= r_rd_bank;
            end
            if (wr_done && w_wr_ready) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (rd_release && w_rd_ready) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end

    // Bank read registers hold between reads, so the mux output holds too.
    assign w_rd_data_s1 = r_rd_zero ? '0 : w_bank_rdata[r_rd_sel];

`ifdef RAM_W_OUTREG_EN
    logic [DATA_WIDTH-1:0] r_rd_data2;
    logic                  r_rd_valid2;

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_rd_data2  <= '0;
            r_rd_valid2 <= 1'b0;
        end else begin
            r_rd_valid2 <= r_rd_valid;
            if (r_rd_valid) begin
                r_rd_data2 <= w_rd_data_s1;
            end
        end
    end

    assign rd_data  = r_rd_data2;
    assign rd_valid = r_rd_valid2;
`else
    assign rd_data  = w_rd_data_s1;
    assign rd_valid = r_rd_valid;
`endif

    assign wr_ready = w_wr_ready;
    assign rd_ready = w_rd_ready;
    assign wr_bank  = r_wr_bank;
    assign rd_bank  = r_rd_bank;
    assign err      = r_err;

endmodule
